// File: rtl/irq_pend.sv
// Interrupt front end: synchronises raw irq lines, detects edge/level events, and
// strobes pend_set once per event until the vector is taken. Option: IRQ_PEND_OVR_CNT_EN.
module irq_pend #(
   parameter int VecSize    = 8,
   parameter int SyncStages = 2,
   parameter int OvrWidth   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [VecSize-1:0]          irq_in,
   input  logic [VecSize-1:0]          cfg_en,
   input  logic [VecSize-1:0]          cfg_edge,
   input  logic [VecSize-1:0]          taken,
   output logic [VecSize-1:0]          pend_set,
`ifdef IRQ_PEND_OVR_CNT_EN
   output logic [VecSize-1:0]          busy,
   output logic [VecSize*OvrWidth-1:0] ovr_cnt,
   input  logic [VecSize-1:0]          ovr_clr
`else
   output logic [VecSize-1:0]          busy
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   if (SyncStages < 2 || OvrWidth < 1) begin : g_bad_param
      $error("irq_pend: SyncStages must be >= 2 and OvrWidth >= 1");
   end

   logic [VecSize-1:0] r_sync [SyncStages];
   logic [VecSize-1:0] r_prev;
   logic [VecSize-1:0] w_s;
   logic [VecSize-1:0] w_event;
   logic [VecSize-1:0] w_wait;
   state_t             r_state [VecSize];
   logic [VecSize-1:0] r_pend;
   logic [VecSize-1:0] r_busy;

   // Synchroniser chain plus one-cycle history of the synchronised line
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < SyncStages; k++) begin
            r_sync[k] <= '0;
         end
         r_prev <= '0;
      end else begin
         r_sync[0] <= irq_in;
         for (int k = 1; k < SyncStages; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
         r_prev <= r_sync[SyncStages-1];
      end
   end

   assign w_s     = r_sync[SyncStages-1];
   assign w_event = (cfg_edge & w_s & ~r_prev) | (~cfg_edge & w_s);

   always_comb begin
      w_wait = '0;
      for (int i = 0; i < VecSize; i++) begin
         w_wait[i] = (r_state[i] == ST_WAIT);
      end
   end

   // Per-source pend FSM; a taken that coincides with a fresh event re-pends in place
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < VecSize; i++) begin
            r_state[i] <= ST_IDLE;
         end
         r_pend <= '0;
         r_busy <= '0;
      end else begin
         for (int i = 0; i < VecSize; i++) begin
            r_pend[i] <= 1'b0;
            case (r_state[i])
               ST_IDLE: begin
                  if (cfg_en[i] && w_event[i]) begin
                     r_state[i] <= ST_WAIT;
                     r_pend[i]  <= 1'b1;
                     r_busy[i]  <= 1'b1;
                  end else begin
                     r_busy[i]  <= 1'b0;
                  end
               end
               ST_WAIT: begin
                  if (!cfg_en[i]) begin
                     r_state[i] <= ST_IDLE;
                     r_busy[i]  <= 1'b0;
                  end else if (taken[i]) begin
                     if (w_event[i]) begin
                        r_pend[i] <= 1'b1;
                        r_busy[i] <= 1'b1;
                     end else begin
                        r_state[i] <= ST_IDLE;
                        r_busy[i]  <= 1'b0;
                     end
                  end else begin
                     r_busy[i] <= 1'b1;
                  end
               end
               default: begin
                  r_state[i] <= ST_IDLE;
                  r_busy[i]  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pend_set = r_pend;
   assign busy     = r_busy;

`ifdef IRQ_PEND_OVR_CNT_EN
   function automatic logic [OvrWidth-1:0] sat_inc(input logic [OvrWidth-1:0] v);
      if (v == {OvrWidth{1'b1}}) begin
         return v;
      end
      return v + 1'b1;
   endfunction

   logic [OvrWidth-1:0] r_ovr [VecSize];
   logic [VecSize-1:0]  w_ovr_inc;

   // Only a genuine new edge while still pended counts as lost
   assign w_ovr_inc = w_wait & cfg_en & cfg_edge & w_event & ~taken;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < VecSize; i++) begin
            r_ovr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < VecSize; i++) begin
            if (ovr_clr[i]) begin
               r_ovr[i] <= '0;
            end else if (w_ovr_inc[i]) begin
               r_ovr[i] <= sat_inc(r_ovr[i]);
            end
         end
      end
   end

   for (genvar g = 0; g < VecSize; g++) begin : g_ovr_out
      assign ovr_cnt[g*OvrWidth +: OvrWidth] = r_ovr[g];
   end
`else
   logic w_unused;
   assign w_unused = ^w_wait;
`endif

endmodule

// File: tb/tb_irq_pend.sv
// Directed bench for irq_pend; build with IRQ_PEND_OVR_CNT_EN to also check overrun counters.
module tb_irq_pend;
   localparam int VS = 8;
   localparam int OW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [VS-1:0] irq_in, cfg_en, cfg_edge, taken;
   logic [VS-1:0] pend_set, busy;
`ifdef IRQ_PEND_OVR_CNT_EN
   logic [VS*OW-1:0] ovr_cnt;
   logic [VS-1:0]    ovr_clr;
`endif

   int checks = 0;
   int errors = 0;

   irq_pend #(.VecSize(VS), .SyncStages(2), .OvrWidth(OW)) dut (
      .clk      (clk),
      .reset    (reset),
      .irq_in   (irq_in),
      .cfg_en   (cfg_en),
      .cfg_edge (cfg_edge),
      .taken    (taken),
      .pend_set (pend_set),
`ifdef IRQ_PEND_OVR_CNT_EN
      .busy     (busy),
      .ovr_cnt  (ovr_cnt),
      .ovr_clr  (ovr_clr)
`else
      .busy     (busy)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; irq_in = '0; cfg_en = '0; cfg_edge = '0; taken = '0;
`ifdef IRQ_PEND_OVR_CNT_EN
      ovr_clr = '0;
`endif
      tick(); tick();
      chk("rst_pend", 32'(pend_set), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
`ifdef IRQ_PEND_OVR_CNT_EN
      chk("rst_ovr", ovr_cnt, 32'h0);
`endif
      reset = 1'b1;
      tick();

      // Edge mode, source 4: latency and hold-until-taken
      cfg_edge = 8'hFF; cfg_en = 8'h10;
      irq_in = 8'h10;
      tick(); chk("e4_lat1", 32'(pend_set), 32'h0);
      tick(); chk("e4_lat2", 32'(pend_set), 32'h0);
      tick(); chk("e4_pend", 32'(pend_set), 32'h10);
      chk("e4_busy", 32'(busy), 32'h10);
      tick(); chk("e4_one", 32'(pend_set), 32'h0);
      chk("e4_busy2", 32'(busy), 32'h10);
      taken = 8'h10; tick(); taken = '0;
      chk("e4_taken_busy", 32'(busy), 32'h0);
      chk("e4_taken_pend", 32'(pend_set), 32'h0);
      tick(); chk("e4_no_repend", 32'(pend_set), 32'h0);
      irq_in = '0; tick(); tick(); tick();

      // Level mode, source 2: re-pend on every taken while held high
      cfg_edge = 8'h00; cfg_en = 8'h04;
      irq_in = 8'h04;
      tick(); tick();
      tick(); chk("l2_pend1", 32'(pend_set), 32'h04);
      chk("l2_busy", 32'(busy), 32'h04);
      tick(); chk("l2_gap1", 32'(pend_set), 32'h0);
      taken = 8'h04; tick(); taken = '0;
      chk("l2_pend2", 32'(pend_set), 32'h04);
      chk("l2_busy2", 32'(busy), 32'h04);
      tick(); chk("l2_gap2", 32'(pend_set), 32'h0);
      taken = 8'h04; tick(); taken = '0;
      chk("l2_pend3", 32'(pend_set), 32'h04);
      tick(); chk("l2_gap3", 32'(pend_set), 32'h0);
      irq_in = '0; tick(); tick(); tick();
      taken = 8'h04; tick(); taken = '0;
      chk("l2_idle_busy", 32'(busy), 32'h0);
      chk("l2_idle_pend", 32'(pend_set), 32'h0);
`ifdef IRQ_PEND_OVR_CNT_EN
      chk("l2_no_ovr", 32'(ovr_cnt[2*OW +: OW]), 32'h0);
`endif

      // Edge mode, source 7: three lost edges while pended
      cfg_edge = 8'hFF; cfg_en = 8'h80;
      irq_in = 8'h80;
      tick(); tick(); tick();
      chk("e7_pend", 32'(pend_set), 32'h80);
      for (int k = 0; k < 3; k++) begin
         irq_in = '0; tick(); tick();
         irq_in = 8'h80; tick(); tick();
         chk("e7_no_pend", 32'(pend_set), 32'h0);
      end
      tick();
      chk("e7_no_pend_end", 32'(pend_set), 32'h0);
      chk("e7_busy", 32'(busy), 32'h80);
`ifdef IRQ_PEND_OVR_CNT_EN
      chk("e7_ovr3", 32'(ovr_cnt[7*OW +: OW]), 32'h3);
      ovr_clr = 8'h80; tick(); ovr_clr = '0;
      chk("e7_ovr_clr", 32'(ovr_cnt[7*OW +: OW]), 32'h0);
`endif
      taken = 8'h80; tick(); taken = '0;
      chk("e7_taken_busy", 32'(busy), 32'h0);
      irq_in = '0; tick(); tick(); tick();

      // Source 0: taken coincides with a new edge
      cfg_en = 8'h01;
      irq_in = 8'h01; tick(); tick(); tick();
      chk("e0_pend1", 32'(pend_set), 32'h01);
      irq_in = '0; tick(); tick();
      irq_in = 8'h01; tick(); tick();
      taken = 8'h01; tick(); taken = '0;
      chk("e0_repend_busy", 32'(busy), 32'h01);
      chk("e0_repend_pend", 32'(pend_set), 32'h01);
`ifdef IRQ_PEND_OVR_CNT_EN
      chk("e0_ovr", 32'(ovr_cnt[0 +: OW]), 32'h0);
`endif
      tick(); chk("e0_gap", 32'(pend_set), 32'h0);
      taken = 8'h01; tick(); taken = '0;
      chk("e0_idle", 32'(busy), 32'h0);
      irq_in = '0; tick(); tick(); tick();

      // Source 3 disabled: edge dropped, enabling with line low is silent
      cfg_en = 8'h00;
      irq_in = 8'h08; tick(); tick(); tick();
      chk("d3_pend", 32'(pend_set), 32'h0);
      tick(); chk("d3_busy", 32'(busy), 32'h0);
      irq_in = '0; tick(); tick(); tick();
      cfg_en = 8'h08; tick(); tick();
      chk("d3_en_pend", 32'(pend_set), 32'h0);
      chk("d3_en_busy", 32'(busy), 32'h0);

      // Simultaneous sources, then disable one while pended
      cfg_en = 8'h21;
      irq_in = 8'h21; tick(); tick(); tick();
      chk("m_pend", 32'(pend_set), 32'h21);
      cfg_en = 8'h01; tick();
      chk("m_dis_busy", 32'(busy), 32'h01);
      chk("m_dis_pend", 32'(pend_set), 32'h0);
      taken = 8'h01; tick(); taken = '0;
      chk("m_taken", 32'(busy), 32'h0);
      irq_in = '0; tick(); tick(); tick();

      // Asynchronous reset mid-strobe, line still high at release
      cfg_en = 8'h02;
      irq_in = 8'h02; tick(); tick(); tick();
      chk("r_pend", 32'(pend_set), 32'h02);
      #1 reset = 1'b0;
      #1;
      chk("r_async_pend", 32'(pend_set), 32'h0);
      chk("r_async_busy", 32'(busy), 32'h0);
      tick(); reset = 1'b1;
      tick(); chk("r_rel1", 32'(pend_set), 32'h0);
      tick();
      tick(); chk("r_rel_pend", 32'(pend_set), 32'h02);
      chk("r_rel_busy", 32'(busy), 32'h02);
      tick(); chk("r_rel_gap", 32'(pend_set), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
